// File: rtl/hash_mem_responder.sv
// hash_mem_responder: word memory behind the hash engine's mem_* port.
// Host loads the image, the block starts the engine and holds the results for readback.
module hash_mem_responder #(
    parameter int DEPTH          = 256,
    parameter int RESULT_WORDS   = 8,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        mem_we,
    input  logic [15:0] mem_addr,
    input  logic [31:0] mem_write_data,
    output logic [31:0] mem_read_data,
    output logic        engine_start,
    input  logic        engine_done,
    input  logic [15:0] out_base,
    input  logic        host_valid,
    output logic        host_ready,
    input  logic [15:0] host_addr,
    input  logic [31:0] host_data,
    input  logic        host_last,
    input  logic [2:0]  host_rd_addr,
    output logic [31:0] host_rd_data,
    input  logic        host_ack,
    output logic        result_valid,
    output logic        timeout,
    output logic        oob_err
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(RESULT_WORDS + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [31:0]   OOB_DATA = 32'hDEADBEEF;
    localparam logic [16:0]   DEPTH17  = 17'(DEPTH);
    localparam logic [16:0]   WIN17    = 17'(RESULT_WORDS);
    localparam logic [CW-1:0] WR_MAX   = CW'(RESULT_WORDS);
    localparam logic [TW-1:0] WD_MAX   = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        LOAD,
        ARMED,
        RUN,
        DONE
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [31:0]   r_mem [DEPTH];
    logic [31:0]   r_mem_rd;
    logic [31:0]   r_host_rd;
    logic          r_engine_start;
    logic          r_timeout;
    logic          r_oob;
    logic [CW-1:0] r_wr_cnt;
    logic [TW-1:0] r_wd_cnt;

    logic          w_mem_oob;
    logic          w_host_oob;
    logic          w_host_wr;
    logic          w_eng_wr;
    logic          w_in_win;
    logic          w_done_ok;
    logic          w_wd_exp;
    logic [16:0]   w_rd_idx;
    logic          w_rd_oob;

    assign w_mem_oob  = {1'b0, mem_addr} >= DEPTH17;
    assign w_host_oob = {1'b0, host_addr} >= DEPTH17;
    assign w_host_wr  = host_valid && (r_state == LOAD);
    assign w_eng_wr   = mem_we && (r_state != LOAD);
    // 17-bit compare so a window near the top of the map never wraps
    assign w_in_win   = ({1'b0, mem_addr} >= {1'b0, out_base}) &&
                        ({1'b0, mem_addr} < ({1'b0, out_base} + WIN17));
    assign w_done_ok  = (r_wr_cnt == WR_MAX) && engine_done;
    assign w_wd_exp   = (r_wd_cnt == WD_MAX);
    assign w_rd_idx   = {1'b0, out_base} + {14'b0, host_rd_addr};
    assign w_rd_oob   = w_rd_idx >= DEPTH17;

    assign mem_read_data = r_mem_rd;
    assign host_rd_data  = r_host_rd;
    assign engine_start  = r_engine_start;
    assign host_ready    = (r_state == LOAD);
    assign result_valid  = (r_state == DONE);
    assign timeout       = r_timeout;
    assign oob_err       = r_oob;

    always_ff @(posedge clk) begin
        if (reset_n) begin
            if (w_host_wr && !w_host_oob) begin
                r_mem[host_addr[AW-1:0]] <= host_data;
            end else if (w_eng_wr && !w_mem_oob) begin
                r_mem[mem_addr[AW-1:0]] <= mem_write_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= LOAD;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            LOAD:    if (host_valid && host_last) w_next = ARMED;
            ARMED:   w_next = RUN;
            RUN:     if (w_done_ok || w_wd_exp) w_next = DONE;
            DONE:    if (host_ack) w_next = LOAD;
            default: w_next = LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_mem_rd       <= '0;
            r_host_rd      <= '0;
            r_engine_start <= 1'b0;
            r_timeout      <= 1'b0;
            r_oob          <= 1'b0;
            r_wr_cnt       <= '0;
            r_wd_cnt       <= '0;
        end else begin
            r_engine_start <= (r_state == ARMED);
            r_mem_rd       <= w_mem_oob ? OOB_DATA : r_mem[mem_addr[AW-1:0]];
            // loaded on the edge entering DONE so it reads 0 in every other state
            if (w_next == DONE) begin
                r_host_rd <= w_rd_oob ? OOB_DATA : r_mem[w_rd_idx[AW-1:0]];
            end else begin
                r_host_rd <= '0;
            end
            if (w_mem_oob || (w_host_wr && w_host_oob)) begin
                r_oob <= 1'b1;
            end
            if (r_state == ARMED) begin
                r_wr_cnt <= '0;
                r_wd_cnt <= '0;
            end else if (r_state == RUN) begin
                if (w_eng_wr && w_in_win && (r_wr_cnt != WR_MAX)) begin
                    r_wr_cnt <= r_wr_cnt + CW'(1);
                end
                if (!w_wd_exp) begin
                    r_wd_cnt <= r_wd_cnt + TW'(1);
                end
            end
            if ((r_state == RUN) && (w_next == DONE)) begin
                r_timeout <= !w_done_ok;
            end else if ((r_state == DONE) && (w_next != DONE)) begin
                r_timeout <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_hash_mem_responder.sv
// Bench for hash_mem_responder: random host/engine traffic against a
// behavioural model, plus directed literal checks on key scenarios.
`timescale 1ns/1ps
module tb_hash_mem_responder;
    localparam int DEPTH = 256;
    localparam int RW    = 8;
    localparam int TO    = 4096;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;
    logic        engine_start;
    logic        engine_done;
    logic [15:0] out_base;
    logic        host_valid;
    logic        host_ready;
    logic [15:0] host_addr;
    logic [31:0] host_data;
    logic        host_last;
    logic [2:0]  host_rd_addr;
    logic [31:0] host_rd_data;
    logic        host_ack;
    logic        result_valid;
    logic        timeout;
    logic        oob_err;

    always #5 clk = ~clk;

    hash_mem_responder #(
        .DEPTH(DEPTH),
        .RESULT_WORDS(RW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .mem_we(mem_we),
        .mem_addr(mem_addr),
        .mem_write_data(mem_write_data),
        .mem_read_data(mem_read_data),
        .engine_start(engine_start),
        .engine_done(engine_done),
        .out_base(out_base),
        .host_valid(host_valid),
        .host_ready(host_ready),
        .host_addr(host_addr),
        .host_data(host_data),
        .host_last(host_last),
        .host_rd_addr(host_rd_addr),
        .host_rd_data(host_rd_data),
        .host_ack(host_ack),
        .result_valid(result_valid),
        .timeout(timeout),
        .oob_err(oob_err)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %h required %h", name, act, exp);
        end
    endtask

    // Reference model: phase 0 load, 1 armed, 2 run, 3 done; -1 before reset.
    logic [31:0] mm [DEPTH];
    bit          mk [DEPTH];
    int          ph = -1;
    int          wr = 0;
    int          wd = 0;
    logic [31:0] e_rd = '0;
    logic [31:0] e_hrd = '0;
    bit          e_rd_k = 1'b0;
    bit          e_hrd_k = 1'b0;
    bit          e_start = 1'b0;
    bit          e_to = 1'b0;
    bit          e_oob = 1'b0;

    always @(posedge clk) begin : model
        int a, h, ra, ob, nph;
        bit fin, wexp;
        a  = int'(mem_addr);
        h  = int'(host_addr);
        ob = int'(out_base);
        ra = ob + int'(host_rd_addr);
        if (!reset_n) begin
            ph = 0; wr = 0; wd = 0;
            e_rd = '0; e_rd_k = 1'b1; e_hrd = '0; e_hrd_k = 1'b1;
            e_start = 1'b0; e_to = 1'b0; e_oob = 1'b0;
        end else if (ph >= 0) begin
            nph = ph;
            e_start = (ph == 1);
            if (a >= DEPTH) e_oob = 1'b1;
            case (ph)
                0: if (host_valid) begin
                    if (h >= DEPTH) e_oob = 1'b1;
                    if (host_last) nph = 1;
                end
                1: begin
                    nph = 2; wr = 0; wd = 0;
                end
                2: begin
                    fin  = (wr == RW) && engine_done;
                    wexp = (wd == TO - 1);
                    if (fin || wexp) begin
                        nph = 3;
                        e_to = !fin;
                    end
                    if (mem_we && a >= ob && a < ob + RW && wr < RW) wr++;
                    if (wd < TO - 1) wd++;
                end
                default: if (host_ack) begin
                    nph = 0;
                    e_to = 1'b0;
                end
            endcase
            if (a >= DEPTH) begin
                e_rd = 32'hDEADBEEF; e_rd_k = 1'b1;
            end else begin
                e_rd = mm[a]; e_rd_k = mk[a];
            end
            if (nph != 3) begin
                e_hrd = '0; e_hrd_k = 1'b1;
            end else if (ra >= DEPTH) begin
                e_hrd = 32'hDEADBEEF; e_hrd_k = 1'b1;
            end else begin
                e_hrd = mm[ra]; e_hrd_k = mk[ra];
            end
            if (ph == 0 && host_valid && h < DEPTH) begin
                mm[h] = host_data; mk[h] = 1'b1;
            end
            if (ph != 0 && mem_we && a < DEPTH) begin
                mm[a] = mem_write_data; mk[a] = 1'b1;
            end
            ph = nph;
        end
    end

    always @(negedge clk) begin
        if (ph >= 0) begin
            if (e_rd_k) chk("mem_read_data", mem_read_data, e_rd);
            if (e_hrd_k) chk("host_rd_data", host_rd_data, e_hrd);
            chk("engine_start", 32'(engine_start), 32'(e_start));
            chk("host_ready", 32'(host_ready), 32'(ph == 0));
            chk("result_valid", 32'(result_valid), 32'(ph == 3));
            chk("timeout", 32'(timeout), 32'(e_to));
            chk("oob_err", 32'(oob_err), 32'(e_oob));
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic idle_engine();
        mem_we = 1'b0;
        mem_addr = '0;
        engine_done = 1'b0;
    endtask

    task automatic rand_engine();
        mem_we = 1'($urandom_range(0, 1));
        mem_addr = 16'($urandom_range(0, DEPTH - 1));
        mem_write_data = $urandom;
    endtask

    task automatic host_word(input logic [15:0] a, input logic [31:0] d, input bit last);
        int gap;
        gap = $urandom_range(0, 2);
        host_valid = 1'b0;
        repeat (gap) tick();
        host_valid = 1'b1;
        host_addr = a;
        host_data = d;
        host_last = last;
        tick();
        host_valid = 1'b0;
        host_last = 1'b0;
    endtask

    task automatic finish_done();
        for (int i = 0; i < 8; i++) begin
            rand_engine();
            host_rd_addr = 3'($urandom_range(0, 7));
            tick();
        end
        idle_engine();
        host_ack = 1'b1;
        tick();
        host_ack = 1'b0;
    endtask

    initial begin : stim
        int cycles;
        reset_n = 1'b0;
        host_valid = 1'b0; host_addr = '0; host_data = '0; host_last = 1'b0;
        host_rd_addr = '0; host_ack = 1'b0; out_base = 16'h0080;
        mem_write_data = '0;
        idle_engine();
        tick();
        tick();
        chk("rst_start", 32'(engine_start), 32'd0);
        chk("rst_valid", 32'(result_valid), 32'd0);
        chk("rst_oob", 32'(oob_err), 32'd0);
        chk("rst_ready", 32'(host_ready), 32'd1);
        chk("rst_rd", mem_read_data, 32'd0);
        reset_n = 1'b1;

        for (int i = 20; i < DEPTH; i++) begin
            rand_engine();
            host_word(16'(i), $urandom, 1'b0);
        end
        for (int i = 0; i < 20; i++) begin
            rand_engine();
            host_word(16'(i), (i == 5) ? 32'h11223344 : $urandom, (i == 19));
        end
        idle_engine();
        chk("armed_ready", 32'(host_ready), 32'd0);
        chk("armed_start", 32'(engine_start), 32'd0);
        tick();
        chk("start_pulse", 32'(engine_start), 32'd1);
        tick();
        chk("start_drop", 32'(engine_start), 32'd0);

        mem_addr = 16'd5;
        tick();
        chk("read_5", mem_read_data, 32'h11223344);
        mem_we = 1'b1;
        mem_write_data = 32'hAA;
        tick();
        chk("read_first", mem_read_data, 32'h11223344);
        mem_we = 1'b0;
        tick();
        chk("read_new", mem_read_data, 32'h000000AA);

        mem_we = 1'b1; mem_addr = 16'h0040; mem_write_data = $urandom;
        tick();
        for (int i = 0; i < 7; i++) begin
            mem_addr = 16'h0080 + 16'(i);
            mem_write_data = 32'(i);
            tick();
        end
        mem_we = 1'b0;
        engine_done = 1'b1;
        tick();
        chk("no_done_at_7", 32'(result_valid), 32'd0);
        engine_done = 1'b0;
        mem_we = 1'b1; mem_addr = 16'h0087; mem_write_data = 32'd7;
        tick();
        mem_we = 1'b0;
        engine_done = 1'b1;
        host_rd_addr = 3'd3;
        tick();
        chk("done_valid", 32'(result_valid), 32'd1);
        chk("done_timeout", 32'(timeout), 32'd0);
        engine_done = 1'b0;
        tick();
        chk("result_3", host_rd_data, 32'd3);
        host_ack = 1'b1;
        tick();
        host_ack = 1'b0;
        chk("ack_ready", 32'(host_ready), 32'd1);
        chk("ack_rd_zero", host_rd_data, 32'd0);

        for (int i = 0; i < 10; i++) begin
            rand_engine();
            host_word(16'($urandom_range(0, DEPTH - 1)), $urandom, (i == 9));
        end
        idle_engine();
        tick();
        cycles = 0;
        while (!result_valid && cycles < TO + 100) begin
            rand_engine();
            tick();
            cycles++;
        end
        chk("timeout_len", 32'(cycles), 32'(TO));
        chk("timeout_flag", 32'(timeout), 32'd1);
        finish_done();
        chk("timeout_clear", 32'(timeout), 32'd0);

        for (int i = 0; i < 4; i++) begin
            host_word(16'($urandom_range(0, DEPTH - 1)), $urandom, (i == 3));
        end
        idle_engine();
        tick();
        cycles = 0;
        for (int i = 0; i < RW; i++) begin
            mem_we = 1'b1;
            mem_addr = 16'h0080 + 16'(i);
            mem_write_data = $urandom;
            tick();
            cycles++;
        end
        while (cycles < TO - 1) begin
            rand_engine();
            tick();
            cycles++;
        end
        chk("run_still", 32'(result_valid), 32'd0);
        idle_engine();
        engine_done = 1'b1;
        tick();
        engine_done = 1'b0;
        chk("both_valid", 32'(result_valid), 32'd1);
        chk("both_timeout", 32'(timeout), 32'd0);
        finish_done();

        chk("pre_oob", 32'(oob_err), 32'd0);
        host_word(16'h0100, 32'h12345678, 1'b0);
        chk("host_oob", 32'(oob_err), 32'd1);
        mem_addr = 16'h0100;
        tick();
        chk("oob_read", mem_read_data, 32'hDEADBEEF);
        mem_addr = 16'h0000;
        tick();
        tick();
        chk("oob_sticky", 32'(oob_err), 32'd1);
        host_word(16'd30, $urandom, 1'b1);
        reset_n = 1'b0;
        tick();
        chk("rst_armed_start", 32'(engine_start), 32'd0);
        chk("rst_oob_clr", 32'(oob_err), 32'd0);
        reset_n = 1'b1;
        tick();
        chk("rst_armed_start2", 32'(engine_start), 32'd0);

        host_word(16'd31, $urandom, 1'b1);
        tick();
        mem_we = 1'b1; mem_addr = 16'h0100; mem_write_data = $urandom;
        tick();
        mem_we = 1'b0;
        tick();
        chk("eng_oob", 32'(oob_err), 32'd1);
        for (int i = 0; i < 20; i++) begin
            rand_engine();
            tick();
        end
        idle_engine();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        chk("rst_run_ready", 32'(host_ready), 32'd1);
        chk("rst_run_start", 32'(engine_start), 32'd0);
        chk("rst_run_valid", 32'(result_valid), 32'd0);
        for (int i = 0; i < 20; i++) begin
            mem_addr = 16'(i);
            tick();
        end
        idle_engine();
        tick();
        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #5ms;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

endmodule
